// File: rtl/sbt_io_pkg.sv
// Shared definitions for the GPIO pad IO-logic slice: output-path modes,
// power-up sequencer states and the default hold length.
package sbt_io_pkg;

  localparam int OUT_COMB = 0;
  localparam int OUT_SDR  = 1;
  localparam int OUT_DDR  = 2;

  localparam int PWRUP_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sbt_io_pwrup_seq.sv
// Power-up sequencer: keeps the pad in its safe state for PWRUP_CYCLES clocks
// after reset release, then hands control to the user (ready=1) until reset.
module sbt_io_pwrup_seq
  import sbt_io_pkg::*;
#(
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic ready,
  output logic active_next
);

  localparam logic [7:0] LAST_COUNT = 8'(PWRUP_CYCLES - 1);

  seq_state_t state;
  logic [7:0] count;

  // High on the rising edge that enters ACTIVE, so registers sample there.
  assign active_next = (state == ACTIVE) || ((state == COUNT) && (count == LAST_COUNT));

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset branch must come first in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
      count <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          state <= COUNT;
        end
        COUNT: begin
          count <= count + 8'd1;
          if (count == LAST_COUNT) begin
            state <= ACTIVE;
            ready <= 1'b1;
          end
        end
        ACTIVE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= HOLD;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sbt_io_ctrl_reg.sv
// Per-pin IO logic in front of the bidirectional GPIO pad: SDR/DDR output,
// registered or direct OE, SDR/DDR input capture with hold, safe power-up.
module sbt_io_ctrl_reg
  import sbt_io_pkg::*;
#(
  parameter int OUT_MODE     = OUT_DDR,
  parameter int OE_REG       = 1,
  parameter int IN_DDR       = 1,
  parameter int PULLUP_EN    = 1,
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d_out_0,
  input  logic d_out_1,
  input  logic oe,
  input  logic latch_in,
  output logic d_in_0,
  output logic d_in_1,
  output logic ready,
  output logic pad_do,
  output logic pad_oen,
  output logic pad_ren,
  output logic pad_ie,
  input  logic pad_di
);

  logic active_next;
  logic r0;
  logic r1p;
  logic r1n;
  logic oe_q;
  logic oe_eff;
  logic do_sel;
  logic capture;

  sbt_io_pwrup_seq #(
    .PWRUP_CYCLES(PWRUP_CYCLES)
  ) u_pwrup_seq (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .active_next (active_next)
  );

  // Output-side registers start sampling on the edge that enters ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0   <= 1'b0;
      r1p  <= 1'b0;
      oe_q <= 1'b0;
    end else if (active_next && ce) begin
      r0   <= d_out_0;
      r1p  <= d_out_1;
      oe_q <= oe;
    end
  end

  // Low-phase copy runs regardless of ce, so a frozen pair keeps repeating.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r1n <= 1'b0;
    end else begin
      r1n <= r1p;
    end
  end

  // Input capture waits for ACTIVE, when pad_ie has actually opened DI.
  assign capture = ready && ce && !latch_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_in_0 <= 1'b0;
    end else if (capture) begin
      d_in_0 <= pad_di;
    end
  end

  generate
    if (IN_DDR != 0) begin : g_in_ddr
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          d_in_1 <= 1'b0;
        end else if (capture) begin
          d_in_1 <= pad_di;
        end
      end
    end else begin : g_in_sdr
      assign d_in_1 = 1'b0;
    end
  endgenerate

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    do_sel = d_out_0;
    case (OUT_MODE)
      OUT_SDR: do_sel = r0;
      OUT_DDR: do_sel = clk ? r0 : r1n;
      default: do_sel = d_out_0;
    endcase
  end

  assign oe_eff  = (OE_REG != 0) ? oe_q : oe;
  assign pad_do  = ready & do_sel;
  assign pad_oen = ready ? ~oe_eff : 1'b1;
  assign pad_ie  = ready;
  assign pad_ren = (PULLUP_EN != 0) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_sbt_io_ctrl_reg.sv
// Bench for sbt_io_ctrl_reg: three configurations share one stimulus, checked
// every half-cycle against an edge-counting model plus literal expectations.
module tb_sbt_io_ctrl_reg;

  localparam int P  = 4;
  localparam int PC = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b1;
  logic d_out_0 = 1'b0;
  logic d_out_1 = 1'b0;
  logic oe = 1'b1;
  logic latch_in = 1'b0;
  logic pad_di = 1'b0;

  logic d_in_0_d, d_in_1_d, ready_d, do_d, oen_d, ren_d, ie_d;
  logic d_in_0_s, d_in_1_s, ready_s, do_s, oen_s, ren_s, ie_s;
  logic d_in_0_c, d_in_1_c, ready_c, do_c, oen_c, ren_c, ie_c;

  int n_checks = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  sbt_io_ctrl_reg #(.OUT_MODE(2), .OE_REG(1), .IN_DDR(1), .PULLUP_EN(1), .PWRUP_CYCLES(P)) u_ddr (
    .clk(clk), .rst(rst), .ce(ce), .d_out_0(d_out_0), .d_out_1(d_out_1), .oe(oe),
    .latch_in(latch_in), .d_in_0(d_in_0_d), .d_in_1(d_in_1_d), .ready(ready_d),
    .pad_do(do_d), .pad_oen(oen_d), .pad_ren(ren_d), .pad_ie(ie_d), .pad_di(pad_di));

  sbt_io_ctrl_reg #(.OUT_MODE(1), .OE_REG(1), .IN_DDR(1), .PULLUP_EN(0), .PWRUP_CYCLES(P)) u_sdr (
    .clk(clk), .rst(rst), .ce(ce), .d_out_0(d_out_0), .d_out_1(d_out_1), .oe(oe),
    .latch_in(latch_in), .d_in_0(d_in_0_s), .d_in_1(d_in_1_s), .ready(ready_s),
    .pad_do(do_s), .pad_oen(oen_s), .pad_ren(ren_s), .pad_ie(ie_s), .pad_di(pad_di));

  sbt_io_ctrl_reg #(.OUT_MODE(0), .OE_REG(0), .IN_DDR(0), .PULLUP_EN(0), .PWRUP_CYCLES(PC)) u_comb (
    .clk(clk), .rst(rst), .ce(ce), .d_out_0(d_out_0), .d_out_1(d_out_1), .oe(oe),
    .latch_in(latch_in), .d_in_0(d_in_0_c), .d_in_1(d_in_1_c), .ready(ready_c),
    .pad_do(do_c), .pad_oen(oen_c), .pad_ren(ren_c), .pad_ie(ie_c), .pad_di(pad_di));

  // Model: rising edges since reset release decide when the pad is live.
  int   edge_cnt = 0;
  logic m_r0 = 1'b0, m_r1p = 1'b0, m_r1n = 1'b0, m_oe_q = 1'b0;
  logic m_din0 = 1'b0, m_din1 = 1'b0, m_din0_c = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= 0;
      m_r0     <= 1'b0;
      m_r1p    <= 1'b0;
      m_oe_q   <= 1'b0;
      m_din0   <= 1'b0;
      m_din0_c <= 1'b0;
    end else begin
      if (edge_cnt < 1000) edge_cnt <= edge_cnt + 1;
      if (edge_cnt >= P && ce) begin
        m_r0   <= d_out_0;
        m_r1p  <= d_out_1;
        m_oe_q <= oe;
      end
      if (edge_cnt >= P + 1 && ce && !latch_in) m_din0 <= pad_di;
      if (edge_cnt >= PC + 1 && ce && !latch_in) m_din0_c <= pad_di;
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_r1n  <= 1'b0;
      m_din1 <= 1'b0;
    end else begin
      m_r1n <= m_r1p;
      if (edge_cnt >= P + 1 && ce && !latch_in) m_din1 <= pad_di;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic rdy, rdyc;
    rdy  = (edge_cnt >= P + 1);
    rdyc = (edge_cnt >= PC + 1);
    check("ddr.ready",   ready_d,  rdy);
    check("ddr.pad_do",  do_d,     rdy ? (clk ? m_r0 : m_r1n) : 1'b0);
    check("ddr.pad_oen", oen_d,    rdy ? ~m_oe_q : 1'b1);
    check("ddr.pad_ie",  ie_d,     rdy);
    check("ddr.pad_ren", ren_d,    1'b0);
    check("ddr.d_in_0",  d_in_0_d, m_din0);
    check("ddr.d_in_1",  d_in_1_d, m_din1);
    check("sdr.ready",   ready_s,  rdy);
    check("sdr.pad_do",  do_s,     rdy ? m_r0 : 1'b0);
    check("sdr.pad_oen", oen_s,    rdy ? ~m_oe_q : 1'b1);
    check("sdr.pad_ie",  ie_s,     rdy);
    check("sdr.pad_ren", ren_s,    1'b1);
    check("sdr.d_in_0",  d_in_0_s, m_din0);
    check("sdr.d_in_1",  d_in_1_s, m_din1);
    check("comb.ready",   ready_c,  rdyc);
    check("comb.pad_do",  do_c,     rdyc ? d_out_0 : 1'b0);
    check("comb.pad_oen", oen_c,    rdyc ? ~oe : 1'b1);
    check("comb.pad_ie",  ie_c,     rdyc);
    check("comb.pad_ren", ren_c,    1'b1);
    check("comb.d_in_0",  d_in_0_c, m_din0_c);
    check("comb.d_in_1",  d_in_1_c, 1'b0);
  endtask

  initial begin
    forever begin
      @(clk);
      #1;
      if (cmp_en) compare_all();
    end
  end

  // Release reset between edges, then walk the power-up count with oe=1.
  task automatic do_powerup();
    rst = 1'b0;
    for (int i = 1; i <= P; i++) begin
      @(posedge clk); #3;
      check("pwrup.ready_low", ready_d, 1'b0);
      check("pwrup.oen_high",  oen_d,   1'b1);
      check("pwrup.ie_low",    ie_d,    1'b0);
    end
    @(posedge clk); #3;
    check("pwrup.ready_high", ready_d, 1'b1);
    check("pwrup.oen_low",    oen_d,   1'b0);
    check("pwrup.ie_high",    ie_d,    1'b1);
    check("pwrup.comb_wait",  ready_c, 1'b0);
    check("pwrup.ren_pu",     ren_d,   1'b0);
    check("pwrup.ren_nopu",   ren_s,   1'b1);
  endtask

  logic [5:0] vecs [8] = '{6'b101101, 6'b010100, 6'b111001, 6'b001110,
                           6'b101100, 6'b011101, 6'b110101, 6'b001100};

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #11;
    check("rst.oen",   oen_d,    1'b1);
    check("rst.do",    do_d,     1'b0);
    check("rst.ie",    ie_d,     1'b0);
    check("rst.ren",   ren_d,    1'b0);
    check("rst.ren_s", ren_s,    1'b1);
    check("rst.ready", ready_d,  1'b0);
    check("rst.din0",  d_in_0_d, 1'b0);
    check("rst.din1",  d_in_1_d, 1'b0);
    do_powerup();

    // DDR pairs 1/0 then 0/1 on successive edges.
    d_out_0 = 1'b1; d_out_1 = 1'b0;
    @(posedge clk); #2;
    d_out_0 = 1'b0; d_out_1 = 1'b1;
    #1 check("ddr.pair0_hi", do_d, 1'b1);
    @(negedge clk); #3 check("ddr.pair0_lo", do_d, 1'b0);
    @(posedge clk); #2;
    d_out_0 = 1'b1; d_out_1 = 1'b1;
    #1 check("ddr.pair1_hi", do_d, 1'b0);
    @(negedge clk); #3 check("ddr.pair1_lo", do_d, 1'b1);

    // SDR freeze under ce=0 while d_out_0 toggles.
    @(posedge clk); #2;
    ce = 1'b0; d_out_0 = 1'b0;
    #1 check("sdr.freeze_start", do_s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      d_out_0 = ~d_out_0;
      #1 check("sdr.frozen", do_s, 1'b1);
    end
    ce = 1'b1; d_out_0 = 1'b0;
    @(posedge clk); #3 check("sdr.resume", do_s, 1'b0);

    // DDR input capture, then hold with latch_in while pad_di inverts.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #2 pad_di = 1'b1;
      @(posedge clk); #2 pad_di = 1'b0;
    end
    @(negedge clk); #3;
    check("in.din0", d_in_0_d, 1'b1);
    check("in.din1", d_in_1_d, 1'b0);
    latch_in = 1'b1; pad_di = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2 pad_di = 1'b1;
      @(negedge clk); #2 pad_di = 1'b0;
    end
    #1;
    check("latch.din0", d_in_0_d, 1'b1);
    check("latch.din1", d_in_1_d, 1'b0);
    latch_in = 1'b0;

    // Asynchronous reset mid-transfer, no clock edge in between.
    d_out_0 = 1'b1; d_out_1 = 1'b1;
    @(posedge clk); #1;
    check("mid.do_before",  do_d,  1'b1);
    check("mid.oen_before", oen_d, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("mid.oen",   oen_d,    1'b1);
    check("mid.do",    do_d,     1'b0);
    check("mid.ready", ready_d,  1'b0);
    check("mid.ie",    ie_d,     1'b0);
    check("mid.din0",  d_in_0_d, 1'b0);
    @(posedge clk); #3;
    do_powerup();

    // Mixed vectors: oe falling with new data, ce gaps, latch, pad_di.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      {d_out_0, d_out_1, oe, ce, latch_in, pad_di} = vecs[i];
      @(negedge clk); #2 pad_di = ~pad_di;
    end
    repeat (3) @(posedge clk);
    #2 cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sbt_io_ctrl_reg.md
Name: sbt_io_ctrl_reg

Overview:
- Per-pin IO logic stage that sits directly upstream of the bidirectional GPIO pad cell.
- Generates the pad cell's DO, OEN, REN and IE controls and captures its DI return.
- Provides SDR/DDR output registers, a registered output enable, SDR/DDR input capture with latch-hold, and a power-up sequencer.
- The sequencer keeps the pad safely tristated until release after reset.

Parameters:
- OUT_MODE, 2, output path: 0 = combinational d_out_0, 1 = rising-edge SDR register, 2 = DDR (d_out_0 in high phase, d_out_1 in low phase).
- OE_REG, 1, 1 = output enable registered on rising edge; 0 = combinational.
- IN_DDR, 1, 1 = d_in_1 captured on falling edge; 0 = d_in_1 tied 0.
- PULLUP_EN, 1, 1 = weak pull-up requested when the pad is not driven.
- PWRUP_CYCLES, 16, clock cycles the pad is held in safe state after reset release; legal range 1..255.

Ports:
- clk  input  1  IO clock, shared by input and output paths.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  clock enable for all data/OE registers; the sequencer ignores it.
- d_out_0  input  1  output data, rising-edge/high-phase.
- d_out_1  input  1  output data, falling-edge/low-phase (DDR only).
- oe  input  1  output enable, active-high.
- latch_in  input  1  1 = hold captured input values.
- d_in_0  output  1  input data captured on rising edge.
- d_in_1  output  1  input data captured on falling edge.
- ready  output  1  1 = sequencer in ACTIVE; pad under user control.
- pad_do  output  1  to pad DO.
- pad_oen  output  1  to pad OEN, active-low enable.
- pad_ren  output  1  to pad REN, active-low pull enable.
- pad_ie  output  1  to pad IE, input enable.
- pad_di  input  1  from pad DI.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation) drives these values:
  - pad_oen=1, pad_do=0, pad_ie=0, pad_ren=~PULLUP_EN.
  - d_in_0=0, d_in_1=0, ready=0.
  - All data registers cleared; sequencer in HOLD with counter=0.
- Sequencer states and transitions:
  - HOLD: first rising edge after rst deasserts goes to COUNT.
  - COUNT: counter increments each rising edge; at counter==PWRUP_CYCLES-1, next state is ACTIVE.
  - ACTIVE: terminal until reset.
  - ready=1 exactly PWRUP_CYCLES+1 rising edges after rst falls.
- Outside ACTIVE, outputs hold their reset values regardless of oe/d_out/ce.
- pad_ie=1 and pad_ren=~PULLUP_EN in ACTIVE. pad_ren stays constant in all states.
- Output path in ACTIVE:
  - OUT_MODE 0: pad_do=d_out_0.
  - OUT_MODE 1: pad_do takes d_out_0 at a rising edge with ce=1; latency 1 cycle.
  - OUT_MODE 2:
    - Rising edge with ce=1 samples d_out_0→r0 and d_out_1→r1p.
    - Falling edge copies r1p→r1n, regardless of ce.
    - pad_do=r0 while clk=1, r1n while clk=0.
    - A pair presented before rising edge N appears as d_out_0 in the high phase after edge N and d_out_1 in the following low phase.
- Output enable:
  - OE_REG=1: pad_oen=~oe_q, with oe_q sampled on rising edge when ce=1.
  - OE_REG=0: pad_oen=~oe.
  - The first rising edge entering ACTIVE already samples oe.
- Input path:
  - Rising edge with ce=1 and latch_in=0: d_in_0<=pad_di.
  - Falling edge with ce=1 and latch_in=0 and IN_DDR=1: d_in_1<=pad_di.
  - latch_in=1 or ce=0 holds both values. latch_in takes priority over new data in the same edge.
  - Capture is inactive outside ACTIVE (pad_ie=0 makes DI a don't-care).
- ce=0 freezes data and OE registers. In DDR mode the r1n copy continues, so the last pair repeats.
- Simultaneous oe fall and new data: the data register still updates; the pad is tristated from the same edge.
- pad_di=X while pad_oen=1 propagates to d_in_0 as X; no masking.

Decomposition:
- Shared package sbt_io_pkg holds:
  - OUT_MODE encodings (OUT_COMB=0, OUT_SDR=1, OUT_DDR=2).
  - Sequencer state enum (HOLD, COUNT, ACTIVE).
  - Default PWRUP_CYCLES.
- One sub-module, sbt_io_pwrup_seq: sequencer plus counter, output ready. All other logic stays in the top module.

Test Plan:
- Reset then release with PWRUP_CYCLES=4, oe=1 → pad_oen=1, pad_ie=0, ready=0 for 4 edges; ready=1 at edge 5; pad_oen=0 at edge 5.
- ACTIVE, OUT_MODE=2, d_out_0/d_out_1 = 1/0 then 0/1 on successive cycles → pad_do = 1,0 then 0,1 in high/low phases, offset by one edge.
- ACTIVE, OUT_MODE=1, ce=0 for 3 cycles while d_out_0 toggles → pad_do frozen at the prior value; resumes 1 cycle after ce=1.
- ACTIVE, IN_DDR=1, pad_di toggled on half-periods 1,0,1,0 → d_in_0=1 and d_in_1=0 stable; latch_in=1 holds them while pad_di inverts.
- rst asserted mid-DDR transfer while pad_oen=0 → pad_oen=1, pad_do=0, ready=0 immediately without a clock edge; full power-up count repeats after release.
- PULLUP_EN=0 → pad_ren=1 in all states; PULLUP_EN=1 → pad_ren=0 through reset and ACTIVE.
